conv_seq_ctrl: RTL and testbench

- Frame-level controller for the 3x3 stride-1 no-padding convolution engine.
- On `start`, loads the nine kernel weights, then streams one DxD frame from an upstream valid/ready source into the engine.
- Tracks row/col position and emits a latency-aligned window-valid strobe marking the (D-2)^2 legal output positions.
- Signals frame completion; sits between the input buffer/DMA and the engine.

---
 rtl/conv_seq_ctrl_pkg.sv | 20 ++
 rtl/conv_tag_delay.sv | 26 ++
 rtl/conv_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared state type, kernel geometry and window-legality helper for conv_seq_ctrl.
// Feature macro used by the top level: CONV_SEQ_CTRL_PERF_EN (stall counter).
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } conv_state_t;

  localparam int KSIZE  = 3;
  localparam int KWORDS = KSIZE * KSIZE;

  // A pixel completes a legal window once a full KSIZE x KSIZE block lies above-left of it.
  function automatic logic win_legal(input int row, input int col);
    return (row >= KSIZE - 1) && (col >= KSIZE - 1);
  endfunction

endpackage

// File: rtl/conv_tag_delay.sv
// Fixed-depth 1-bit shift register that realigns window tags with the engine output.
module conv_tag_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tag,
  output logic o_tag
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_tag = r_sr[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Frame controller for the 3x3 convolution engine: kernel load, pixel stream, window tagging.
// Define CONV_SEQ_CTRL_PERF_EN to add the saturating stall_cnt output.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int D          = 220,
  parameter int DATA_WIDTH = 32,
  parameter int LAT        = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         k_valid,
  input  logic [DATA_WIDTH-1:0]        k_data,
  output logic                         k_ready,
  input  logic                         s_valid,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         s_ready,
  output logic                         eng_valid,
  output logic [DATA_WIDTH-1:0]        eng_pxl,
  output logic [KWORDS*DATA_WIDTH-1:0] kernel_flat,
  output logic                         win_valid,
`ifdef CONV_SEQ_CTRL_PERF_EN
  output logic [31:0]                  stall_cnt,
`endif
  output logic                         err_underrun
);

  localparam int CW  = $clog2(D);
  localparam int DCW = $clog2(LAT + 2);

  conv_state_t           r_state;
  conv_state_t           w_state_next;
  logic [3:0]            r_kidx;
  logic [CW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [DCW-1:0]        r_drain_cnt;
  logic                  r_started;
  logic                  r_eng_valid;
  logic [DATA_WIDTH-1:0] r_eng_pxl;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_kernel [KWORDS];

  logic w_k_acc;
  logic w_s_acc;
  logic w_last_px;
  logic w_bubble;
  logic w_start_go;
  logic w_tag;

  assign w_start_go = (r_state == IDLE) && start;
  assign w_k_acc    = (r_state == LOAD_K) && k_valid;
  assign w_s_acc    = (r_state == STREAM) && s_valid;
  assign w_last_px  = (r_row == CW'(D - 1)) && (r_col == CW'(D - 1));
  // Only gaps after the first pixel count as underruns; waiting for the frame to begin is normal.
  assign w_bubble   = (r_state == STREAM) && !s_valid && r_started;
  assign w_tag      = w_s_acc && win_legal(int'(r_row), int'(r_col));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    k_ready      = 1'b0;
    s_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = LOAD_K;
      end
      LOAD_K: begin
        busy    = 1'b1;
        k_ready = 1'b1;
        if (k_valid && (r_kidx == 4'(KWORDS - 1))) w_state_next = STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid && w_last_px) w_state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Final drain cycle coincides with the last tag leaving the delay line.
        if (r_drain_cnt == DCW'(LAT)) begin
          done         = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_kidx      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_drain_cnt <= '0;
      r_started   <= 1'b0;
      r_eng_valid <= 1'b0;
      r_eng_pxl   <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < KWORDS; i++) r_kernel[i] <= '0;
    end else begin
      r_eng_valid <= w_s_acc;
      if (w_s_acc) r_eng_pxl <= s_data;

      if (w_start_go) begin
        r_kidx    <= '0;
        r_row     <= '0;
        r_col     <= '0;
        r_started <= 1'b0;
        r_err     <= 1'b0;
      end

      if (w_k_acc) begin
        r_kernel[r_kidx] <= k_data;
        r_kidx           <= r_kidx + 4'd1;
      end

      if (w_s_acc) begin
        r_started <= 1'b1;
        if (r_col == CW'(D - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_bubble) r_err <= 1'b1;

      if (r_state == DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
      else                  r_drain_cnt <= '0;
    end
  end

`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset || w_start_go) begin
      r_stall_cnt <= '0;
    end else if (w_bubble && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  generate
    for (genvar gi = 0; gi < KWORDS; gi++) begin : g_kflat
      assign kernel_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_kernel[gi];
    end
  endgenerate

  assign eng_valid    = r_eng_valid;
  assign eng_pxl      = r_eng_pxl;
  assign err_underrun = r_err;

  conv_tag_delay #(
    .DEPTH(LAT + 1)
  ) u_tag_delay (
    .clk  (clk),
    .reset(reset),
    .i_tag(w_tag),
    .o_tag(win_valid)
  );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl with D=5 and D=3 instances; a table of frame scenarios is checked
// cycle by cycle against a frame timeline model. Honours CONV_SEQ_CTRL_PERF_EN for stall_cnt.
module tb_conv_seq_ctrl;

  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int MAXC = 256;
  localparam int NVEC = 11;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] start;
  logic k_valid, s_valid;
  logic [DW-1:0] k_data, s_data;
  logic sel;

  logic busy_a, done_a, k_ready_a, s_ready_a, eng_valid_a, win_valid_a, err_a;
  logic busy_b, done_b, k_ready_b, s_ready_b, eng_valid_b, win_valid_b, err_b;
  logic [DW-1:0] eng_pxl_a, eng_pxl_b;
  logic [9*DW-1:0] kflat_a, kflat_b;
`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] stall_a, stall_b;
`endif

  always #5 clk = ~clk;

  conv_seq_ctrl #(.D(5), .DATA_WIDTH(DW), .LAT(LAT)) u_dut5 (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy_a), .done(done_a),
    .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready_a),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .eng_valid(eng_valid_a), .eng_pxl(eng_pxl_a), .kernel_flat(kflat_a),
    .win_valid(win_valid_a),
`ifdef CONV_SEQ_CTRL_PERF_EN
    .stall_cnt(stall_a),
`endif
    .err_underrun(err_a)
  );

  conv_seq_ctrl #(.D(3), .DATA_WIDTH(DW), .LAT(LAT)) u_dut3 (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy_b), .done(done_b),
    .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready_b),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .eng_valid(eng_valid_b), .eng_pxl(eng_pxl_b), .kernel_flat(kflat_b),
    .win_valid(win_valid_b),
`ifdef CONV_SEQ_CTRL_PERF_EN
    .stall_cnt(stall_b),
`endif
    .err_underrun(err_b)
  );

  logic m_busy, m_done, m_kr, m_sr, m_ev, m_win, m_err;
  logic [DW-1:0] m_pxl;
  logic [9*DW-1:0] m_kflat;
  logic [31:0] m_stall;

  always_comb begin
    m_busy  = sel ? busy_b      : busy_a;
    m_done  = sel ? done_b      : done_a;
    m_kr    = sel ? k_ready_b   : k_ready_a;
    m_sr    = sel ? s_ready_b   : s_ready_a;
    m_ev    = sel ? eng_valid_b : eng_valid_a;
    m_win   = sel ? win_valid_b : win_valid_a;
    m_err   = sel ? err_b       : err_a;
    m_pxl   = sel ? eng_pxl_b   : eng_pxl_a;
    m_kflat = sel ? kflat_b     : kflat_a;
`ifdef CONV_SEQ_CTRL_PERF_EN
    m_stall = sel ? stall_b : stall_a;
`else
    m_stall = 32'd0;
`endif
  end

  typedef struct {
    int sel;
    int kgap;
    int stall_after;
    int stall_len;
    bit rnd;
    bit extra_start;
    int abort_px;
    int exp_wins;
    int exp_err;
    int exp_stalls;
  } vec_t;

  vec_t tbl[NVEC];
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model_pxl [2];

  function automatic vec_t mk(int s, int kg, int sa, int sl, bit r, bit ex, int ab,
                              int w, int e, int st);
    vec_t v;
    v.sel = s; v.kgap = kg; v.stall_after = sa; v.stall_len = sl; v.rnd = r;
    v.extra_start = ex; v.abort_px = ab; v.exp_wins = w; v.exp_err = e; v.exp_stalls = st;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero_state(input string tag);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk({tag, "_busy"}, s, m_busy, 0);
      chk({tag, "_done"}, s, m_done, 0);
      chk({tag, "_k_ready"}, s, m_kr, 0);
      chk({tag, "_s_ready"}, s, m_sr, 0);
      chk({tag, "_eng_valid"}, s, m_ev, 0);
      chk({tag, "_win_valid"}, s, m_win, 0);
      chk({tag, "_err"}, s, m_err, 0);
      chk({tag, "_eng_pxl"}, s, m_pxl, 0);
      for (int i = 0; i < 9; i++) chk({tag, "_kslot"}, i, m_kflat[i*DW +: DW], 0);
`ifdef CONV_SEQ_CTRL_PERF_EN
      chk({tag, "_stall_cnt"}, s, m_stall, 0);
`endif
    end
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    bit kv[MAXC], sv[MAXC], acc[MAXC];
    logic [DW-1:0] kd[MAXC], sd[MAXC];
    logic [DW-1:0] kw[9];
    int pidx[MAXC];
    int dd, kcnt, k9, pcnt, plast, first, stalls, err_from, stall_rem, ncyc, wins, pe;
    bit aborted, exp_win;

    dd = (v.sel != 0) ? 3 : 5;
    kcnt = 0; k9 = -1; pcnt = 0; plast = -1; first = -1; stalls = 0;
    err_from = -1; stall_rem = 0; ncyc = 0; wins = 0; aborted = 0;
    for (int i = 0; i < 9; i++) kw[i] = v.rnd ? DW'($urandom) : DW'(i + 1);
    for (int c = 0; c < MAXC; c++) begin
      kv[c] = 0; sv[c] = 0; acc[c] = 0; pidx[c] = 0;
      kd[c] = $urandom; sd[c] = $urandom;
    end

    // Timeline: LOAD_K opens the cycle after start, STREAM the cycle after the 9th word,
    // DRAIN holds LAT+1 cycles after the last pixel, then one IDLE cycle is observed.
    for (int c = 1; c < MAXC && ncyc == 0; c++) begin
      if (k9 < 0) begin
        kv[c] = ((c - 1) % v.kgap) == 0;
        sv[c] = 1'b1;
        if (kv[c]) begin
          kd[c] = kw[kcnt];
          kcnt++;
          if (kcnt == 9) k9 = c;
        end
      end else if (plast < 0) begin
        kv[c] = 1'b1;
        if (v.rnd) sv[c] = ($urandom_range(0, 3) != 0);
        else if (stall_rem > 0) begin sv[c] = 1'b0; stall_rem--; end
        else sv[c] = 1'b1;
        if (sv[c]) begin
          acc[c] = 1'b1;
          pidx[c] = pcnt;
          if (first < 0) first = c;
          if (!v.rnd && pcnt == v.stall_after) stall_rem = v.stall_len;
          pcnt++;
          if (pcnt == dd * dd) plast = c;
        end else if (first >= 0) begin
          stalls++;
          if (err_from < 0) err_from = c + 1;
        end
      end else begin
        sv[c] = (c <= plast + LAT + 1);
        if (c == plast + LAT + 2) ncyc = c + 1;
      end
    end
    if (ncyc == 0) begin
      chk("schedule_built", idx, 0, 1);
      return;
    end

    sel = v.sel[0];
    for (int c = 0; c < ncyc && !aborted; c++) begin
      @(posedge clk); #1;
      start = 2'b00;
      start[v.sel] = (c == 0) || (v.extra_start && c == k9 + 3);
      k_valid = kv[c]; k_data = kd[c];
      s_valid = sv[c]; s_data = sd[c];
      reset = (v.abort_px >= 0) && acc[c] && (pidx[c] == v.abort_px);
      @(negedge clk);
      pe = (c >= LAT + 1) ? pidx[c-LAT-1] : 0;
      exp_win = (c >= LAT + 1) && acc[c-LAT-1] && (pe / dd >= 2) && (pe % dd >= 2);
      if (c >= 1 && acc[c-1]) model_pxl[v.sel] = sd[c-1];
      chk("busy", c, m_busy, (c >= 1 && c <= plast + LAT + 1));
      chk("k_ready", c, m_kr, (c >= 1 && c <= k9));
      chk("s_ready", c, m_sr, (c > k9 && c <= plast));
      chk("eng_valid", c, m_ev, (c >= 1 && acc[c-1]));
      chk("eng_pxl", c, m_pxl, model_pxl[v.sel]);
      chk("win_valid", c, m_win, exp_win);
      chk("done", c, m_done, (c == plast + LAT + 1));
      if (c >= 1) chk("err_underrun", c, m_err, (err_from >= 0 && c >= err_from));
      if (m_win) wins++;
      if (reset) aborted = 1'b1;
    end

    if (aborted) begin
      @(posedge clk); #1;
      reset = 1'b0; start = 2'b00; k_valid = 1'b0; s_valid = 1'b0;
      @(negedge clk);
      model_pxl[0] = '0; model_pxl[1] = '0;
      chk_zero_state("after_abort");
      sel = v.sel[0];
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("abort_no_done", c, m_done, 0);
        chk("abort_idle", c, m_busy, 0);
      end
      $display("frame %0d: D=%0d aborted by reset at pixel %0d", idx, dd, v.abort_px);
      return;
    end

    chk("win_count_model", idx, wins, (dd - 2) * (dd - 2));
    chk("win_count_table", idx, wins, v.exp_wins);
    chk("err_final", idx, m_err, (err_from >= 0));
    if (v.exp_err >= 0) chk("err_table", idx, m_err, v.exp_err);
    if (v.exp_stalls >= 0) chk("stalls_table", idx, stalls, v.exp_stalls);
    for (int i = 0; i < 9; i++) chk("kernel_slot", i, m_kflat[i*DW +: DW], kw[i]);
`ifdef CONV_SEQ_CTRL_PERF_EN
    chk("stall_cnt", idx, m_stall, stalls);
`endif
    $display("frame %0d: D=%0d kgap=%0d wins=%0d err=%0b stalls=%0d cycles=%0d", idx, dd,
             v.kgap, wins, m_err, stalls, ncyc);
  endtask

  initial begin
    //           sel kgap stall@ len rnd extra abort wins err stalls
    tbl[0]  = mk(0,  1,   -1,    0,  0,  0,    -1,   9,   0,  0);
    tbl[1]  = mk(0,  1,    7,    3,  0,  0,    -1,   9,   1,  3);
    tbl[2]  = mk(0,  1,   -1,    0,  0,  1,    -1,   9,   0,  0);
    tbl[3]  = mk(0,  1,   -1,    0,  0,  0,    12,  -1,  -1, -1);
    tbl[4]  = mk(0,  1,   -1,    0,  0,  0,    -1,   9,   0,  0);
    tbl[5]  = mk(0,  3,   -1,    0,  0,  0,    -1,   9,   0,  0);
    tbl[6]  = mk(1,  1,   -1,    0,  0,  0,    -1,   1,   0,  0);
    tbl[7]  = mk(0,  1,   -1,    0,  1,  0,    -1,   9,  -1, -1);
    tbl[8]  = mk(1,  2,   -1,    0,  1,  1,    -1,   1,  -1, -1);
    tbl[9]  = mk(0,  2,   -1,    0,  1,  0,    -1,   9,  -1, -1);
    tbl[10] = mk(1,  1,   -1,    0,  1,  0,    -1,   1,  -1, -1);

    reset = 1'b1; start = 2'b00; k_valid = 1'b0; s_valid = 1'b0;
    k_data = '0; s_data = '0; sel = 1'b0;
    model_pxl[0] = '0; model_pxl[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_state("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_frame(i, tbl[i]);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
